// File: rtl/mv_bcd_converter_pkg.sv
// Shared constants, FSM state encoding and helpers for the millivolt
// binary-to-BCD converter that feeds the 7-segment display multiplexer.
package mv_bcd_converter_pkg;

    // Bits per packed BCD digit.
    localparam int BCD_DIGIT_W  = 4;

    // Number of sequencer channels (tags 0..12) and the width of the tag.
    localparam int NUM_CHANNELS = 13;
    localparam int CH_W         = 4;

    // Millivolt value width from the scaler and the matching digit count.
    localparam int MV_WIDTH     = 12;
    localparam int MV_DIGITS    = 4;

    // Converter control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // 10**n, used to confirm at elaboration that the digit field can hold
    // the largest binary input.
    function automatic longint unsigned pow10(input int n);
        longint unsigned acc;
        acc = 64'd1;
        for (int k = 0; k < n; k++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/mv_bcd_converter_add3_nibble.sv
// Double-dabble correction for one BCD digit: a nibble of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3_nibble (
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);

    // Pure combinational correction; values above 9 never occur in a
    // well-formed BCD field, so the 4-bit wrap is irrelevant.
    always_comb begin
        o_nibble = i_nibble;
        if (i_nibble >= 4'd5) begin
            o_nibble = i_nibble + 4'd3;
        end
    end

endmodule

// File: rtl/mv_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter: one shift per clock,
// valid/ready input handshake, registered digits, blanking mask and channel tag.
module mv_bcd_converter #(
    parameter int WIDTH  = mv_bcd_converter_pkg::MV_WIDTH,
    parameter int DIGITS = mv_bcd_converter_pkg::MV_DIGITS,
    parameter int CH_W   = mv_bcd_converter_pkg::CH_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [CH_W-1:0]       in_ch,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [DIGITS-1:0]     out_lz,
    output logic [CH_W-1:0]       out_ch
);

    import mv_bcd_converter_pkg::*;

    // Scratch register layout: {BCD digits, binary value}, shifted as one.
    localparam int BCD_W  = DIGITS * BCD_DIGIT_W;
    localparam int TOT_W  = BCD_W + WIDTH;
    localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // Largest binary input versus largest value the digit field can hold.
    localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;
    localparam longint unsigned MAX_BCD = pow10(DIGITS) - 64'd1;

    generate
        if (MAX_BIN > MAX_BCD) begin : g_range_check
            $error("mv_bcd_converter: DIGITS too small for WIDTH");
        end
    endgenerate

    conv_state_t            r_state;
    logic [TOT_W-1:0]       r_shift;
    logic [CNT_W-1:0]       r_cnt;
    logic [CH_W-1:0]        r_ch;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [BCD_W-1:0]       r_out_bcd;
    logic [DIGITS-1:0]      r_out_lz;
    logic [CH_W-1:0]        r_out_ch;

    logic [BCD_W-1:0]       w_bcd_field;
    logic [BCD_W-1:0]       w_bcd_adj;
    logic [TOT_W-1:0]       w_shift_next;
    logic [DIGITS-1:0]      w_lz;

    assign w_bcd_field = r_shift[TOT_W-1:WIDTH];

    // One add-3 corrector per digit, all applied before the common shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3_nibble u_add3 (
                .i_nibble (w_bcd_field[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_nibble (w_bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Corrected digits plus untouched binary part, shifted left by one.
    assign w_shift_next = {w_bcd_adj, r_shift[WIDTH-1:0]} << 1;

    // Leading-zero mask: a digit is blanked only when it and every higher
    // digit are zero; the units digit is always shown.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
            if (gi == 0) begin : g_units
                assign w_lz[gi] = 1'b0;
            end else if (gi == DIGITS - 1) begin : g_top
                assign w_lz[gi] = (w_bcd_field[gi*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
            end else begin : g_mid
                assign w_lz[gi] = (w_bcd_field[gi*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0)
                                  && w_lz[gi+1];
            end
        end
    endgenerate

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_ch        <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_bcd   <= '0;
            r_out_lz    <= '0;
            r_out_ch    <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_shift    <= {{BCD_W{1'b0}}, in_data};
                        r_ch       <= in_ch;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_out_bcd   <= w_bcd_field;
                    r_out_lz    <= w_lz;
                    r_out_ch    <= r_ch;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_bcd   = r_out_bcd;
    assign out_lz    = r_out_lz;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mv_bcd_converter.sv
// Self-checking bench for mv_bcd_converter: fixed vectors, hand-built
// handshake/reset sequences and a random sweep against a decimal model.
module tb_mv_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic [3:0]  in_ch;
    logic        out_valid;
    logic [15:0] out_bcd;
    logic [3:0]  out_lz;
    logic [3:0]  out_ch;

    mv_bcd_converter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ch     (in_ch),
        .out_valid (out_valid),
        .out_bcd   (out_bcd),
        .out_lz    (out_lz),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  lz;
        logic [3:0]  ch;
    } exp_t;

    typedef struct {
        logic [11:0] data;
        logic [3:0]  ch;
        logic [15:0] bcd;
        logic [3:0]  lz;
    } vec_t;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_accept  = 0;
    int   n_valid   = 0;
    int   cyc       = 0;
    logic prev_valid = 1'b0;
    exp_t exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Decimal reference: digits by division, blanking from the top down.
    function automatic exp_t model(input int v, input logic [3:0] ch);
        exp_t e;
        int   d;
        bit   all_zero;
        e.bcd = '0;
        e.lz  = '0;
        e.ch  = ch;
        all_zero = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            d = (v / (10 ** i)) % 10;
            e.bcd[i*4 +: 4] = 4'(d);
            all_zero = all_zero && (d == 0);
            if (i > 0) e.lz[i] = all_zero;
        end
        return e;
    endfunction

    // Result monitor: every pulse is one cycle wide and matches the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                n_valid++;
                if (prev_valid) check("pulse_width", 2, 1);
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_bcd", out_bcd, e.bcd);
                    check("out_lz", out_lz, e.lz);
                    check("out_ch", out_ch, e.ch);
                    $display("result bcd=%04h lz=%04b ch=%0d", out_bcd, out_lz, out_ch);
                end
            end
            prev_valid = out_valid;
        end
    end

    // Present a value, wait (bounded) for in_ready, and return the cycle
    // number of the accepting edge. Leaves in_valid asserted.
    task automatic send(input logic [11:0] d, input logic [3:0] ch,
                        input exp_t e, output int acc);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_ch    = ch;
        while (!in_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            acc = -1;
        end else begin
            exp_q.push_back(e);
            n_accept++;
            @(posedge clk); #1;
            acc = cyc;
        end
    endtask

    task automatic wait_result(input int acc, output int lat);
        int budget;
        budget = 0;
        while (!out_valid && budget < 60) begin
            @(posedge clk); #1;
            budget++;
        end
        check("out_valid_seen", out_valid, 1);
        lat = cyc - acc;
    endtask

    vec_t vecs[8];
    exp_t e;
    int   acc, acc2, lat, gap, v;

    initial begin
        vecs[0] = '{12'd0,    4'd0,  16'h0000, 4'b1110};
        vecs[1] = '{12'd806,  4'd3,  16'h0806, 4'b1000};
        vecs[2] = '{12'd4095, 4'd1,  16'h4095, 4'b0000};
        vecs[3] = '{12'd7,    4'd2,  16'h0007, 4'b1110};
        vecs[4] = '{12'd55,   4'd5,  16'h0055, 4'b1100};
        vecs[5] = '{12'd1000, 4'd9,  16'h1000, 4'b0000};
        vecs[6] = '{12'd10,   4'd15, 16'h0010, 4'b1100};
        vecs[7] = '{12'd999,  4'd11, 16'h0999, 4'b1000};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_ch    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bcd", out_bcd, 0);
        check("rst_out_lz", out_lz, 0);
        check("rst_out_ch", out_ch, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", in_ready, 1);

        // Table: latency, ready on completion and hold behaviour.
        for (int i = 0; i < 8; i++) begin
            e.bcd = vecs[i].bcd; e.lz = vecs[i].lz; e.ch = vecs[i].ch;
            send(vecs[i].data, vecs[i].ch, e, acc);
            in_valid = 1'b0;
            $display("vec %0d: data=%0d ch=%0d accepted at cycle %0d", i, vecs[i].data, vecs[i].ch, acc);
            wait_result(acc, lat);
            check("latency", lat, 13);
            check("ready_at_done", in_ready, 1);
            repeat (3) @(posedge clk);
            #1;
            check("hold_bcd", out_bcd, vecs[i].bcd);
            check("hold_lz", out_lz, vecs[i].lz);
            check("pulse_gone", out_valid, 0);
        end

        // 3300 on channel 12: busy for cycles 1..12 after accept.
        e.bcd = 16'h3300; e.lz = 4'b0000; e.ch = 4'd12;
        send(12'd3300, 4'd12, e, acc);
        in_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check("busy_in_ready", in_ready, 0);
            check("busy_out_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        check("done_out_valid", out_valid, 1);
        check("done_in_ready", in_ready, 1);
        $display("seq 3300: accepted at cycle %0d, done at cycle %0d", acc, cyc);

        // Back-to-back with in_valid held high: second accept 14 cycles on.
        e.bcd = 16'h4095; e.lz = 4'b0000; e.ch = 4'd4;
        send(12'd4095, 4'd4, e, acc);
        e.bcd = 16'h0007; e.lz = 4'b1110; e.ch = 4'd6;
        send(12'd7, 4'd6, e, acc2);
        in_valid = 1'b0;
        check("b2b_accept_gap", acc2 - acc, 14);
        wait_result(acc2, lat);
        check("b2b_latency", lat, 13);
        $display("seq b2b: accepts at cycles %0d and %0d", acc, acc2);

        // Reset mid-conversion discards the result and clears outputs.
        e.bcd = 16'h1234; e.lz = 4'b0000; e.ch = 4'd8;
        send(12'd1234, 4'd8, e, acc);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_bcd", out_bcd, 0);
        check("midrst_out_lz", out_lz, 0);
        check("midrst_out_ch", out_ch, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        n_accept--;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", out_valid, 0);
        end
        e.bcd = 16'h0055; e.lz = 4'b1100; e.ch = 4'd3;
        send(12'd55, 4'd3, e, acc);
        in_valid = 1'b0;
        wait_result(acc, lat);
        check("post_rst_latency", lat, 13);
        $display("seq reset: recovery conversion accepted at cycle %0d", acc);

        // Random sweep with random idle gaps between requests.
        for (int n = 0; n < 200; n++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            v = $urandom_range(0, 4095);
            e = model(v, 4'($urandom_range(0, 15)));
            send(12'(v), e.ch, e, acc);
        end
        in_valid = 1'b0;

        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("pending_results", exp_q.size(), 0);
        check("valid_count", n_valid, n_accept);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
